// File: rtl/gigatron_run_control.sv
// Run/halt/step sequencer for the Gigatron core: debounces the board buttons,
// drives the CPU reset and clock enable, halts on a PC breakpoint and counts instructions.
module gigatron_run_control #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESET_CYCLES    = 16
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Switch_1,
  input  logic        i_Switch_2,
  input  logic        i_Switch_3,
  input  logic        i_Switch_4,
  input  logic [15:0] i_Pc,
  input  logic [15:0] i_Brk_Addr,
  output logic        o_Cpu_Reset,
  output logic        o_Cpu_Enable,
  output logic [1:0]  o_State,
  output logic        o_Halted_Brk,
  output logic [7:0]  o_Exec_Count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  logic [3:0] sw_raw;
  logic [3:0] level;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // The counter only runs while the synchronized input disagrees with the
  // accepted level, so any bounce back to the old level restarts it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic            sync1_q;
      logic            sync2_q;
      logic            lvl_q;
      logic [DB_W-1:0] cnt_q;

      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          lvl_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sw_raw[gi];
          sync2_q <= sync1_q;
          if (sync2_q == lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl_q <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign level[gi] = lvl_q;
    end
  endgenerate

  logic toggle_prev_q, step_prev_q, rst_prev_q;
  logic toggle_press, step_press, rst_press;
  logic brk_en;

  assign toggle_press = level[0] & ~toggle_prev_q;
  assign step_press   = level[1] & ~step_prev_q;
  assign rst_press    = level[3] & ~rst_prev_q;
  assign brk_en       = level[2];

  state_t          state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            armed_q, armed_d;
  logic            halted_brk_q, halted_brk_d;
  logic [7:0]      exec_cnt_q;
  logic            brk_hit;
  logic            cpu_enable;

  assign brk_hit    = brk_en & armed_q & (i_Pc == i_Brk_Addr);
  assign cpu_enable = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~brk_hit);

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    armed_d      = armed_q;
    halted_brk_d = halted_brk_q;
    if (state_q == ST_RUN && cpu_enable) begin
      armed_d = 1'b1;
    end
    if (rst_press) begin
      state_d      = ST_RESET;
      rst_cnt_d    = '0;
      armed_d      = 1'b1;
      halted_brk_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          armed_d = 1'b1;
          if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
            state_d   = ST_RUN;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (toggle_press) begin
            state_d = ST_HALT;
          end else if (brk_hit) begin
            state_d      = ST_HALT;
            halted_brk_d = 1'b1;
          end
        end
        ST_HALT: begin
          // Disarm on resume so the instruction at the breakpoint executes once.
          if (toggle_press) begin
            state_d      = ST_RUN;
            armed_d      = 1'b0;
            halted_brk_d = 1'b0;
          end else if (step_press) begin
            state_d      = ST_STEP;
            halted_brk_d = 1'b0;
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= ST_RESET;
      rst_cnt_q     <= '0;
      armed_q       <= 1'b1;
      halted_brk_q  <= 1'b0;
      exec_cnt_q    <= '0;
      toggle_prev_q <= 1'b0;
      step_prev_q   <= 1'b0;
      rst_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      armed_q       <= armed_d;
      halted_brk_q  <= halted_brk_d;
      toggle_prev_q <= level[0];
      step_prev_q   <= level[1];
      rst_prev_q    <= level[3];
      if (state_d == ST_RESET) begin
        exec_cnt_q <= '0;
      end else if (cpu_enable) begin
        exec_cnt_q <= exec_cnt_q + 8'd1;
      end
    end
  end

  assign o_Cpu_Reset  = (state_q == ST_RESET);
  assign o_Cpu_Enable = cpu_enable;
  assign o_State      = state_q;
  assign o_Halted_Brk = halted_brk_q;
  assign o_Exec_Count = exec_cnt_q;

endmodule
